// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state encoding and default widths.
package mdu_pkg;

    localparam int MDU_XLEN  = 32;
    localparam int MDU_CNT_W = 5;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef logic [1:0] mdu_state_t;

    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_MUL  = 2'd1;
    localparam mdu_state_t ST_DIV  = 2'd2;
    localparam mdu_state_t ST_FIX  = 2'd3;

    // Signed operations are the ones whose operands go through magnitude/sign handling.
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between a core pipeline (master) and the MDU (slave).
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) ();

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_divider.sv
// One combinational step of restoring division on unsigned magnitudes:
// shift the next dividend bit into the partial remainder and trial-subtract.
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // Trial subtraction; a set top bit means the divisor did not fit.
    always_comb begin
        shifted_s = {rem, quo[XLEN-1]};
        diff_s    = shifted_s - {1'b0, divisor};
        if (diff_s[XLEN]) begin
            rem_next = shifted_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_next = diff_s[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative MIPS-style multiply/divide unit with HI/LO result registers.
// Optional MDU_FAST_MULT_EN: single-cycle combinational multiply; division stays iterative.
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);

    mdu_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              done_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic [XLEN-1:0]   mag_r;
    logic [XLEN-1:0]   acc_hi_r;
    logic [XLEN-1:0]   acc_lo_r;
    logic              is_div_r;
    logic              neg_res_r;
    logic              neg_rem_r;
    logic              div_zero_r;

    logic              accept_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic              cnt_last_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [XLEN-1:0]   div_rem_s;
    logic [XLEN-1:0]   div_quo_s;
`ifdef MDU_FAST_MULT_EN
    logic [2*XLEN-1:0] fast_prod_s;
`endif

    mdu_divider #(.XLEN(XLEN)) u_divider (
        .rem      (acc_hi_r),
        .quo      (acc_lo_r),
        .divisor  (mag_r),
        .rem_next (div_rem_s),
        .quo_next (div_quo_s)
    );

    // Request decode, operand magnitudes, multiply step and final sign correction.
    always_comb begin
        accept_s   = bus.start & ~busy_r;
        a_neg_s    = op_is_signed(bus.op) & bus.a[XLEN-1];
        b_neg_s    = op_is_signed(bus.op) & bus.b[XLEN-1];
        a_mag_s    = a_neg_s ? (~bus.a + {{(XLEN-1){1'b0}}, 1'b1}) : bus.a;
        b_mag_s    = b_neg_s ? (~bus.b + {{(XLEN-1){1'b0}}, 1'b1}) : bus.b;
        cnt_last_s = (cnt_r == CNT_W'(XLEN-1));
        if (acc_lo_r[0]) begin
            mul_sum_s = {1'b0, acc_hi_r} + {1'b0, mag_r};
        end else begin
            mul_sum_s = {1'b0, acc_hi_r};
        end
        prod_s = {acc_hi_r, acc_lo_r};
        if (neg_res_r) begin
            prod_fix_s = ~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            prod_fix_s = prod_s;
        end
        // Divide by zero leaves all-ones in LO whatever the operand signs.
        if (div_zero_r) begin
            quo_fix_s = {XLEN{1'b1}};
        end else if (neg_res_r) begin
            quo_fix_s = ~acc_lo_r + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            quo_fix_s = acc_lo_r;
        end
        if (neg_rem_r) begin
            rem_fix_s = ~acc_hi_r + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            rem_fix_s = acc_hi_r;
        end
`ifdef MDU_FAST_MULT_EN
        fast_prod_s = {{XLEN{a_neg_s}}, bus.a} * {{XLEN{b_neg_s}}, bus.b};
`endif
    end

    // Control FSM, iteration counter, datapath registers and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= {XLEN{1'b0}};
            lo_r       <= {XLEN{1'b0}};
            mag_r      <= {XLEN{1'b0}};
            acc_hi_r   <= {XLEN{1'b0}};
            acc_lo_r   <= {XLEN{1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        case (bus.op)
                            MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                                hi_r   <= fast_prod_s[2*XLEN-1:XLEN];
                                lo_r   <= fast_prod_s[XLEN-1:0];
                                done_r <= 1'b1;
`else
                                state_r    <= ST_MUL;
                                busy_r     <= 1'b1;
                                cnt_r      <= {CNT_W{1'b0}};
                                mag_r      <= a_mag_s;
                                acc_hi_r   <= {XLEN{1'b0}};
                                acc_lo_r   <= b_mag_s;
                                is_div_r   <= 1'b0;
                                neg_res_r  <= a_neg_s ^ b_neg_s;
                                neg_rem_r  <= 1'b0;
                                div_zero_r <= 1'b0;
`endif
                            end
                            MDU_DIV, MDU_DIVU: begin
                                state_r    <= ST_DIV;
                                busy_r     <= 1'b1;
                                cnt_r      <= {CNT_W{1'b0}};
                                mag_r      <= b_mag_s;
                                acc_hi_r   <= {XLEN{1'b0}};
                                acc_lo_r   <= a_mag_s;
                                is_div_r   <= 1'b1;
                                neg_res_r  <= a_neg_s ^ b_neg_s;
                                neg_rem_r  <= a_neg_s;
                                div_zero_r <= (bus.b == {XLEN{1'b0}});
                            end
                            MDU_MTHI: begin
                                hi_r <= bus.a;
                            end
                            MDU_MTLO: begin
                                lo_r <= bus.a;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    {acc_hi_r, acc_lo_r} <= {mul_sum_s, acc_lo_r[XLEN-1:1]};
                    if (cnt_last_s) begin
                        state_r <= ST_FIX;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    acc_hi_r <= div_rem_s;
                    acc_lo_r <= div_quo_s;
                    if (cnt_last_s) begin
                        state_r <= ST_FIX;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    if (is_div_r) begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end else begin
                        hi_r <= prod_fix_s[2*XLEN-1:XLEN];
                        lo_r <= prod_fix_s[XLEN-1:0];
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a reference model predicts HI/LO, busy window and done pulse
// per accepted request; a negedge monitor compares every cycle.
module tb_mdu;
    import mdu_pkg::*;

    localparam int XLEN = 32;
`ifdef MDU_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        int        t0;
        int        due;
        bit        is_done;
        bit        busy_win;
        bit        set_hi;
        bit        set_lo;
        bit [31:0] hi;
        bit [31:0] lo;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_due = 0;
    ev_t  q[$];
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_if #(.XLEN(XLEN)) bus ();

    mdu #(.XLEN(XLEN), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the MIPS HI/LO semantics.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 64'd0;
        case (op)
            MDU_MULT:  r = sa * sb;
            MDU_MULTU: r = {32'd0, a} * {32'd0, b};
            MDU_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    qq = sa / sb;
                    rr = sa % sb;
                    r = {rr[31:0], qq[31:0]};
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Monitor: apply due events to the expected HI/LO and compare all outputs.
    always @(negedge clk) begin
        ev_t e;
        bit  exp_done;
        bit  exp_busy;
        exp_done = 1'b0;
        exp_busy = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.set_hi) exp_hi = e.hi;
            if (e.set_lo) exp_lo = e.lo;
            exp_done = e.is_done;
        end
        if (q.size() > 0 && q[0].busy_win && cyc >= q[0].t0 && cyc < q[0].due) exp_busy = 1'b1;
        check("hi", 64'(bus.hi), 64'(exp_hi));
        check("lo", 64'(bus.lo), 64'(exp_lo));
        check("busy", 64'(bus.busy), 64'(exp_busy));
        check("done", 64'(bus.done), 64'(exp_done));
    end

    // Drive inputs for the next rising edge and record the predicted outcome.
    task automatic drive_now(input bit s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        logic [63:0] r;
        bus.start = s;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (s && cyc >= last_due && op <= MDU_MTLO) begin
            e.t0 = cyc + 1;
            e.set_hi = 1'b1;
            e.set_lo = 1'b1;
            e.is_done = 1'b1;
            e.busy_win = 1'b0;
            r = ref_model(op, a, b);
            e.hi = r[63:32];
            e.lo = r[31:0];
            if (op == MDU_MTHI || op == MDU_MTLO) begin
                e.due = e.t0;
                e.is_done = 1'b0;
                e.set_hi = (op == MDU_MTHI);
                e.set_lo = (op == MDU_MTLO);
                e.hi = a;
                e.lo = a;
            end else if (FAST && (op == MDU_MULT || op == MDU_MULTU)) begin
                e.due = e.t0;
            end else begin
                e.due = e.t0 + XLEN + 1;
                e.busy_win = 1'b1;
                last_due = e.due;
            end
            q.push_back(e);
        end
    endtask

    task automatic drive(input bit s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        drive_now(s, op, a, b);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Idle with changing operands until the next negedge is a free cycle.
    task automatic wait_free();
        for (int i = 0; i < 200 && cyc + 1 < last_due; i++)
            drive(1'b0, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
    endtask

    task automatic do_reset_mid_op();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.start = 1'b0;
        q.delete();
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        last_due = 0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_now(1'b1, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive(1'b0, MDU_MULT, 32'h1234_0000, 32'h5);
        drive(1'b1, MDU_MTLO, 32'hDEAD_BEEF, 32'h0);
        wait_free();
        drive(1'b1, MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_free();
        drive(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_free();
        drive(1'b1, MDU_DIVU, 32'h0000_0007, 32'h0000_0000);
        wait_free();
        drive(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_free();
        drive(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0000);
        wait_free();
        drive(1'b1, MDU_MTHI, 32'h1234_5678, 32'h0);
        drive(1'b1, MDU_MTLO, 32'h9ABC_DEF0, 32'h0);
        drive(1'b1, 3'd6, 32'h1111_1111, 32'h2222_2222);
        drive(1'b1, 3'd7, 32'h3333_3333, 32'h4444_4444);
        drive(1'b0, MDU_MULT, 32'h0, 32'h0);

        drive(1'b1, MDU_DIV, 32'h0000_0064, 32'h0000_0007);
        repeat (9) drive(1'b0, MDU_DIV, rand_operand(), rand_operand());
        do_reset_mid_op();
        rst_n = 1'b1;
        drive_now(1'b1, MDU_DIVU, 32'h0000_0064, 32'h0000_0007);
        wait_free();

        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rand_operand(), rand_operand());

        for (int i = 0; i < 200 && q.size() > 0; i++)
            drive(1'b0, MDU_MULT, 32'd0, 32'd0);
        drive(1'b0, MDU_MULT, 32'd0, 32'd0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still pending, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
